fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameters, one per line:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, beat width; equals FIFO width
- MAX_BURST, 8, maximum beats per locked grant (lock mode only)
REQ-002 The block SHALL have ports, one per line:
- clk_i  input  1  single clock, rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- req_valid_i  input  NUM_REQ  per-requester beat valid
- req_data_i  input  NUM_REQ*DATA_WIDTH  beat data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  input  NUM_REQ  last beat of a packet (used only in lock mode)
- req_ready_o  output  NUM_REQ  per-requester beat accepted
- fifo_full_i  input  1  FIFO full flag
- fifo_wr_en_o  output  1  FIFO write enable
- fifo_din_o  output  DATA_WIDTH  FIFO write data
- grant_o  output  NUM_REQ  registered one-hot grant; all zero when idle
- busy_o  output  1  grant active

Function
REQ-003 The FSM SHALL have two states, IDLE (grant_o=0) and GRANT (grant_o one-hot).
REQ-004 In IDLE, any req_valid_i bit SHALL move the FSM to GRANT on the next edge, granting the round-robin winner.
- Arbitration latency: 1 cycle.
REQ-005 Round-robin search SHALL start at index rr_ptr and wrap modulo NUM_REQ.
- rr_ptr SHALL become g+1 (wrapping) whenever grant g is released.
REQ-006 req_ready_o[k] SHALL equal grant_o[k] AND NOT fifo_full_i, combinationally.
REQ-007 A transfer SHALL occur when req_valid_i[g] and req_ready_o[g] are both high.
- On a transfer: fifo_wr_en_o=1 and fifo_din_o=req_data_i[g] in the same cycle.
- Otherwise: fifo_wr_en_o=0 and fifo_din_o=0.
REQ-008 A granted requester SHALL keep the grant while it has no transfer, including while fifo_full_i=1.
- The grant SHALL NOT be preempted by any other requester.
REQ-009 On a transfer that releases the grant, the next state SHALL be chosen from the current req_valid_i, searching from g+1:
- any valid -> GRANT to the winner, with no idle cycle;
- none valid -> IDLE.
REQ-010 The block SHALL sustain 1 beat/cycle across grant changes.
REQ-011 fifo_wr_en_o SHALL never assert while fifo_full_i=1.
REQ-012 busy_o SHALL equal (state==GRANT).

Reset
REQ-013 Assertion of rstn_i=0 SHALL immediately, asynchronously set:
- state=IDLE, grant_o=0, rr_ptr=0, beat counter=0;
- req_ready_o=0, fifo_wr_en_o=0, busy_o=0.
REQ-014 Reset asserted mid-packet SHALL abandon the packet with no further FIFO write.
REQ-015 After rstn_i deasserts, requester 0 SHALL have highest priority on the first arbitration.

Configuration
REQ-016 Packet-lock mode SHALL be compiled in only when macro FIFO_WR_ARB_PKT_LOCK_EN is defined.
REQ-017 Without FIFO_WR_ARB_PKT_LOCK_EN:
- every transfer SHALL release the grant;
- req_last_i SHALL be ignored;
- no beat counter SHALL exist.
REQ-018 With FIFO_WR_ARB_PKT_LOCK_EN, a transfer SHALL release the grant only if:
- req_last_i[g]=1, or
- the beat counter reaches MAX_BURST.
REQ-019 The beat counter SHALL:
- be $clog2(MAX_BURST+1) bits wide;
- increment on each transfer;
- clear on release.
REQ-020 In lock mode, deassertion of req_valid_i[g] mid-packet SHALL NOT release the grant.

Verification
REQ-021 Benches (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4) SHALL cover:
- Reset release; req_valid_i=4'b0001, data 0xA0 -> grant_o=0001 one cycle later; fifo_wr_en_o=1 with 0xA0 that cycle.
- All four requesters valid continuously, full=0, lock off -> writes ordered req0,1,2,3,0,...; one beat per cycle after first grant.
- req2 granted, fifo_full_i=1 for 5 cycles while req1 valid -> grant_o stays 0100, fifo_wr_en_o=0 throughout; req2 beat written on the first cycle full=0.
- Lock on; req0 sends 6-beat packet, last on beat 6, req1 valid -> req0 beats 1-4, req1 beat, then req0 beats 5-6.
- Lock on; req3 mid-packet drops valid 2 cycles while req0 valid -> grant_o stays 1000, no write from req0.
- rstn_i asserted mid-transfer -> req_ready_o, fifo_wr_en_o, grant_o zero the same cycle, before the next clock edge.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that merges NUM_REQ beat streams into a single FIFO write port.
// Define FIFO_WR_ARB_PKT_LOCK_EN to hold a grant until packet end or MAX_BURST beats.
module fifo_wr_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_din_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GntOne = NUM_REQ'(1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PtrW-1:0]     rr_ptr_q;
    logic [PtrW-1:0]     grant_idx;
    logic [PtrW-1:0]     next_idx;
    logic [PtrW-1:0]     search_start;
    logic [PtrW-1:0]     winner;
    logic [PtrW-1:0]     idx_p;
    logic                found;
    logic                xfer;
    logic                release_grant;

    assign grant_o     = grant_q;
    assign busy_o      = (state_q == StGrant);
    assign req_ready_o = grant_q & ~{NUM_REQ{fifo_full_i}};
    assign xfer        = |(req_valid_i & req_ready_o);
    assign fifo_wr_en_o = xfer;

    always_comb begin
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) grant_idx = PtrW'(k);
        end
    end

    assign next_idx = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;

    // Idle arbitration starts at rr_ptr; a releasing grant searches from g+1 directly.
    assign search_start = (state_q == StIdle) ? rr_ptr_q : next_idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_p  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_p = PtrW'((32'(search_start) + i) % NUM_REQ);
            if (!found && req_valid_i[idx_p]) begin
                found  = 1'b1;
                winner = idx_p;
            end
        end
    end

    always_comb begin
        fifo_din_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (req_valid_i[k] && req_ready_o[k]) begin
                fifo_din_o = fifo_din_o | req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    logic [CntW-1:0] beat_cnt_q;

    assign release_grant = xfer &&
        (req_last_i[grant_idx] || ((beat_cnt_q + CntW'(1)) == CntW'(MAX_BURST)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            beat_cnt_q <= '0;
        end else if (release_grant) begin
            beat_cnt_q <= '0;
        end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
        end
    end
`else
    logic [31:0] unused_cfg;
    assign unused_cfg    = {31'(MAX_BURST), ^req_last_i};
    assign release_grant = xfer;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StGrant;
                        grant_q <= GntOne << winner;
                    end
                end
                StGrant: begin
                    if (release_grant) begin
                        rr_ptr_q <= next_idx;
                        if (found) begin
                            grant_q <= GntOne << winner;
                        end else begin
                            state_q <= StIdle;
                            grant_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized and directed bench for fifo_wr_arb against a cycle-level ownership model.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

    localparam int NumReq   = 4;
    localparam int DataW    = 32;
    localparam int MaxBurst = 4;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    localparam bit Lock = 1'b1;
`else
    localparam bit Lock = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rstn_i = 1'b0;
    logic [NumReq-1:0]        req_valid_i = '0;
    logic [NumReq*DataW-1:0]  req_data_i = '0;
    logic [NumReq-1:0]        req_last_i = '0;
    logic [NumReq-1:0]        req_ready_o;
    logic                     fifo_full_i = 1'b0;
    logic                     fifo_wr_en_o;
    logic [DataW-1:0]         fifo_din_o;
    logic [NumReq-1:0]        grant_o;
    logic                     busy_o;

    fifo_wr_arb #(
        .NUM_REQ   (NumReq),
        .DATA_WIDTH(DataW),
        .MAX_BURST (MaxBurst)
    ) u_dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .fifo_full_i (fifo_full_i),
        .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_din_o  (fifo_din_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner of the grant (-1 = nobody), round-robin start, beats in current grant.
    int owner = -1;
    int rr    = 0;
    int beats = 0;
    int wq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int start);
        for (int i = 0; i < NumReq; i++) begin
            int idx;
            idx = (start + i) % NumReq;
            if (req_valid_i[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1;
        rr    = 0;
        beats = 0;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
        req_valid_i = v;
        req_last_i  = l;
        fifo_full_i = f;
        for (int k = 0; k < NumReq; k++) begin
            req_data_i[k*DataW +: DataW] = {8'(k), 24'($urandom)};
        end
    endtask

    task automatic settle();
        #3;
    endtask

    // Compare outputs with the model, then advance both across one clock edge.
    task automatic tick();
        logic [3:0] eg;
        bit x;
        eg = (owner < 0) ? 4'b0 : (4'b1 << owner);
        x  = (owner >= 0) && req_valid_i[owner] && !fifo_full_i;
        check_eq("grant", 32'(grant_o), 32'(eg));
        check_eq("ready", 32'(req_ready_o), fifo_full_i ? 32'd0 : 32'(eg));
        check_eq("wr_en", 32'(fifo_wr_en_o), 32'(x));
        check_eq("din", fifo_din_o, x ? req_data_i[owner*DataW +: DataW] : 32'd0);
        check_eq("busy", 32'(busy_o), 32'(owner >= 0));
        if (x) wq.push_back(owner);
        @(posedge clk_i);
        if (owner < 0) begin
            owner = pick(rr);
        end else if (x) begin
            beats++;
            if (!Lock || req_last_i[owner] || beats == MaxBurst) begin
                rr    = (owner + 1) % NumReq;
                beats = 0;
                owner = pick(rr);
            end
        end
        #1;
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f);
        drive(v, l, f);
        settle();
        tick();
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        drive(4'b0, 4'b0, 1'b0);
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent0;
        int n;
        #1;
        check_eq("rst_grant", 32'(grant_o), 32'd0);
        check_eq("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;

        // First arbitration after reset: grant one cycle later, write in that cycle.
        drive(4'b0001, 4'b0001, 1'b0);
        req_data_i[31:0] = 32'hA0;
        settle();
        check_eq("first_idle_grant", 32'(grant_o), 32'd0);
        tick();
        drive(4'b0001, 4'b0001, 1'b0);
        req_data_i[31:0] = 32'hA0;
        settle();
        check_eq("first_grant", 32'(grant_o), 32'b0001);
        check_eq("first_wr", 32'(fifo_wr_en_o), 32'd1);
        check_eq("first_din", fifo_din_o, 32'hA0);
        tick();

        // All valid, packets of one beat: strict rotation, one beat per cycle.
        do_reset();
        wq.delete();
        for (int c = 0; c < 10; c++) step(4'b1111, 4'b1111, 1'b0);
        check_eq("rr_count", 32'(wq.size()), 32'd9);
        for (int i = 0; i < wq.size(); i++) check_eq("rr_order", 32'(wq[i]), 32'(i % NumReq));

        // Full stalls a granted requester without losing the grant to another.
        do_reset();
        step(4'b0100, 4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0110, 4'b1111, 1'b1);
            settle();
            check_eq("full_hold_grant", 32'(grant_o), 32'b0100);
            check_eq("full_no_wr", 32'(fifo_wr_en_o), 32'd0);
            tick();
        end
        drive(4'b0110, 4'b1111, 1'b0);
        settle();
        check_eq("unfull_wr", 32'(fifo_wr_en_o), 32'd1);
        check_eq("unfull_src", 32'(fifo_din_o[31:24]), 32'd2);
        tick();

        if (Lock) begin
            // 6-beat packet from req0 is split at MAX_BURST, req1 slips in between.
            do_reset();
            wq.delete();
            sent0 = 0;
            for (int c = 0; c < 20 && sent0 < 6; c++) begin
                n = wq.size();
                step(4'b0011, {2'b00, 1'b1, 1'(sent0 == 5)}, 1'b0);
                if (wq.size() > n && wq[$] == 0) sent0++;
            end
            check_eq("lock_beats0", 32'(sent0), 32'd6);
            check_eq("lock_len", 32'(wq.size()), 32'd7);
            for (int i = 0; i < wq.size() && i < 7; i++) begin
                check_eq("lock_order", 32'(wq[i]), (i == 4) ? 32'd1 : 32'd0);
            end

            // Valid drop mid-packet keeps the grant.
            do_reset();
            step(4'b1000, 4'b0000, 1'b0);
            step(4'b1000, 4'b0000, 1'b0);
            for (int c = 0; c < 2; c++) begin
                drive(4'b0001, 4'b0000, 1'b0);
                settle();
                check_eq("lock_hold_grant", 32'(grant_o), 32'b1000);
                check_eq("lock_hold_wr", 32'(fifo_wr_en_o), 32'd0);
                tick();
            end
        end

        // Asynchronous reset mid-transfer clears outputs before the next edge.
        do_reset();
        for (int c = 0; c < 3; c++) step(4'b1111, 4'b0000, 1'b0);
        drive(4'b1111, 4'b0000, 1'b0);
        settle();
        rstn_i = 1'b0;
        #1;
        check_eq("arst_ready", 32'(req_ready_o), 32'd0);
        check_eq("arst_wr", 32'(fifo_wr_en_o), 32'd0);
        check_eq("arst_grant", 32'(grant_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        check_eq("arst_no_wr", 32'(fifo_wr_en_o), 32'd0);
        rstn_i = 1'b1;

        // Random traffic, last and full.
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
